// File: rtl/smart_lighting_if.sv
// Zone lighting bus: raw sensor/switch levels in, registered lamp enable out.
// No handshake; levels are sampled every clock by the controller.
interface smart_lighting_if;
  logic motion_detected;
  logic manual_override;
  logic light_on;

  modport master (output motion_detected, output manual_override, input light_on);
  modport slave  (input motion_detected, input manual_override, output light_on);
endinterface

// File: rtl/smart_lighting.sv
// Occupancy light controller: synchronised motion/override drive an OFF/ON/HOLD/OVERRIDE FSM.
// Latency SYNC_STAGES edges per input plus one registered edge; no backpressure, inputs sampled every cycle.
module smart_lighting #(
  parameter int HOLD_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            reset,
  smart_lighting_if.slave bus
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    ON       = 2'd1,
    HOLD     = 2'd2,
    OVERRIDE = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] m_sync_q;
  logic [SYNC_STAGES-1:0] o_sync_q;
  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   light_q;

  logic m_s;
  logic o_s;

  assign m_s = m_sync_q[SYNC_STAGES-1];
  assign o_s = o_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      m_sync_q <= '0;
      o_sync_q <= '0;
      state_q  <= OFF;
      cnt_q    <= '0;
      light_q  <= 1'b0;
    end else begin
      m_sync_q <= {m_sync_q[SYNC_STAGES-2:0], bus.motion_detected};
      o_sync_q <= {o_sync_q[SYNC_STAGES-2:0], bus.manual_override};

      // Override dominates everything, including a simultaneous motion edge.
      if (o_s) begin
        state_q <= OVERRIDE;
        light_q <= 1'b1;
      end else begin
        unique case (state_q)
          OVERRIDE: begin
            light_q <= 1'b1;
            if (m_s) begin
              state_q <= ON;
            end else begin
              state_q <= HOLD;
              cnt_q   <= HOLD_LOAD;
            end
          end
          OFF: begin
            if (m_s) begin
              state_q <= ON;
              light_q <= 1'b1;
            end
          end
          ON: begin
            light_q <= 1'b1;
            if (!m_s) begin
              state_q <= HOLD;
              cnt_q   <= HOLD_LOAD;
            end
          end
          HOLD: begin
            // Retrigger wins even at count zero so the lamp never blinks.
            if (m_s) begin
              state_q <= ON;
              light_q <= 1'b1;
            end else if (cnt_q == '0) begin
              state_q <= OFF;
              light_q <= 1'b0;
            end else begin
              cnt_q   <= cnt_q - CW'(1);
              light_q <= 1'b1;
            end
          end
          default: begin
            state_q <= OFF;
            light_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.light_on = light_q;

endmodule

// File: tb/tb_smart_lighting.sv
// Scoreboard bench: two builds (HOLD_CYCLES=16 and 1) share directed and random stimulus.
// A presence-window reference model predicts light_on per edge; a negedge monitor compares.
module tb_smart_lighting;

  localparam int S    = 2;
  localparam int H0   = 16;
  localparam int H1   = 1;
  localparam int NMAX = 20000;

  bit   clk;
  logic reset;
  logic m_r;
  logic o_r;

  always #5 clk = ~clk;

  smart_lighting_if bus0 ();
  smart_lighting_if bus1 ();

  assign bus0.motion_detected = m_r;
  assign bus0.manual_override = o_r;
  assign bus1.motion_detected = m_r;
  assign bus1.manual_override = o_r;

  smart_lighting #(.HOLD_CYCLES(H0), .SYNC_STAGES(S)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  smart_lighting #(.HOLD_CYCLES(H1), .SYNC_STAGES(S)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: history of raw samples per edge.
  bit m_raw [NMAX];
  bit o_raw [NMAX];
  bit r_raw [NMAX];
  int edge_k  = 0;
  int last0   = -1000000;
  int last1   = -1000000;
  bit started = 0;

  bit exp_q0 [$];
  bit exp_q1 [$];
  int idx_q  [$];

  // An input is visible to the controller S edges after it was sampled,
  // unless a reset landed on any edge in between (which clears the chain).
  function automatic bit seen(input int k, input bit is_motion);
    bit v;
    if (k < S) return 1'b0;
    v = is_motion ? m_raw[k-S] : o_raw[k-S];
    for (int j = k - S; j < k; j++)
      if (r_raw[j]) v = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    bit pres;
    if (edge_k < NMAX) begin
      m_raw[edge_k] = m_r;
      o_raw[edge_k] = o_r;
      r_raw[edge_k] = reset;
      if (reset) begin
        last0 = -1000000;
        last1 = -1000000;
        exp_q0.push_back(1'b0);
        exp_q1.push_back(1'b0);
      end else begin
        pres = seen(edge_k, 1'b1) || seen(edge_k, 1'b0);
        if (pres) begin
          last0 = edge_k;
          last1 = edge_k;
        end
        // Lamp is lit while presence lasts and for HOLD_CYCLES edges after the last one.
        exp_q0.push_back((edge_k - last0) <= H0);
        exp_q1.push_back((edge_k - last1) <= H1);
      end
      idx_q.push_back(edge_k);
      edge_k  = edge_k + 1;
      started = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit e0;
    bit e1;
    int k;
    if (started) begin
      if (exp_q0.size() == 0 || exp_q1.size() == 0 || idx_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL scoreboard_empty got=none required=entry");
      end else begin
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        k  = idx_q.pop_front();
        checks = checks + 1;
        if (bus0.light_on !== e0) begin
          errors = errors + 1;
          $display("FAIL light_on_h16 edge=%0d got=%b required=%b", k, bus0.light_on, e0);
        end
        checks = checks + 1;
        if (bus1.light_on !== e1) begin
          errors = errors + 1;
          $display("FAIL light_on_h1 edge=%0d got=%b required=%b", k, bus1.light_on, e1);
        end
      end
    end
  end

  task automatic cyc(input int n, input bit m, input bit o, input bit r);
    repeat (n) begin
      m_r   = m;
      o_r   = o;
      reset = r;
      @(negedge clk);
    end
  endtask

  initial begin
    m_r   = 1'b0;
    o_r   = 1'b0;
    reset = 1'b1;

    // Reset with both inputs high, then release.
    cyc(2, 1, 1, 1);
    cyc(4, 1, 1, 0);
    cyc(25, 0, 0, 0);

    // Basic on / hold / off.
    cyc(2, 0, 0, 1);
    cyc(2, 1, 0, 0);
    cyc(25, 0, 0, 0);

    // Retrigger during hold, then a fresh hold.
    cyc(2, 1, 0, 0);
    cyc(3, 0, 0, 0);
    cyc(2, 1, 0, 0);
    cyc(25, 0, 0, 0);

    // Retrigger right at the end of the hold window.
    cyc(2, 1, 0, 0);
    cyc(H0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(25, 0, 0, 0);

    // Override alone for 5 cycles.
    cyc(5, 0, 1, 0);
    cyc(25, 0, 0, 0);

    // Override asserted during hold.
    cyc(2, 1, 0, 0);
    cyc(6, 0, 0, 0);
    cyc(3, 0, 1, 0);
    cyc(25, 0, 0, 0);

    // Motion and override together; override released while motion stays high.
    cyc(3, 1, 1, 0);
    cyc(4, 1, 0, 0);
    cyc(25, 0, 0, 0);

    // Reset in the middle of a hold.
    cyc(2, 1, 0, 0);
    cyc(11, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(25, 0, 0, 0);

    // Single-cycle motion pulse.
    cyc(1, 1, 0, 0);
    cyc(25, 0, 0, 0);

    // Randomised segments.
    for (int i = 0; i < 300; i++) begin
      int len;
      bit m;
      bit o;
      bit r;
      len = $urandom_range(1, 22);
      m   = ($urandom_range(0, 2) == 0);
      o   = ($urandom_range(0, 5) == 0);
      r   = ($urandom_range(0, 29) == 0);
      cyc(r ? 1 : len, m, o, r);
    end
    cyc(25, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
